// File: rtl/router_ctrl_fsm_pkg.sv
// Shared router definitions: FSM state encoding, the reserved destination
// address and address-decode helpers used by the control, register and sync blocks.
package router_ctrl_fsm_pkg;

   localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
   localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd3;
   localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd4;
   localparam logic [2:0] ST_LOAD_PARITY        = 3'd5;
   localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd6;
   localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd7;

   // Address 3 has no FIFO behind it; headers carrying it are dropped.
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = ST_DECODE_ADDRESS,
      LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
      LOAD_DATA          = ST_LOAD_DATA,
      FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
      LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
      LOAD_PARITY        = ST_LOAD_PARITY,
      CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY
   } state_t;

   function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
      logic [2:0] sel;
      case (addr)
         2'b00:   sel = 3'b001;
         2'b01:   sel = 3'b010;
         2'b10:   sel = 3'b100;
         default: sel = 3'b000;
      endcase
      return sel;
   endfunction

   // Per-destination flag lookup; the invalid address reads as 0.
   function automatic logic flag_at(input logic [2:0] flags, input logic [1:0] addr);
      return |(flags & addr_onehot(addr));
   endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Signal bundle between the router control FSM and its neighbours
// (source, FIFOs, register block, sync block).
interface router_ctrl_fsm_if;

   logic       pkt_valid;
   logic [1:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_pkt_valid;

   logic       busy;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic [2:0] write_enb;
   logic       rst_int_reg;
   logic [1:0] dest_addr;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, write_enb, rst_int_reg, dest_addr
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, write_enb, rst_int_reg, dest_addr
   );

endinterface

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading into the destination FIFO and raises back-pressure to the source.
//
// state              | meaning
// -------------------+-------------------------------------------------
// DECODE_ADDRESS     | idle; waiting for a header byte
// LOAD_FIRST_DATA    | header byte written to the destination FIFO
// LOAD_DATA          | payload bytes streaming while pkt_valid is high
// FIFO_FULL_STATE    | destination FIFO full; source held off
// LOAD_AFTER_FULL    | write the byte held during the full condition
// LOAD_PARITY        | write the parity byte
// CHECK_PARITY_ERROR | register block compares parity, clears its state
// WAIT_TILL_EMPTY    | destination FIFO still draining an earlier packet
module router_ctrl_fsm
   import router_ctrl_fsm_pkg::*;
(
   input logic               clock,
   input logic               reset,
   router_ctrl_fsm_if.slave  bus
);

   state_t     state, state_nxt;
   logic [1:0] dest_q, dest_nxt;

   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= DECODE_ADDRESS;
         dest_q <= 2'b00;
      end else begin
         state  <= state_nxt;
         dest_q <= dest_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dest_nxt  = dest_q;
      // A timeout on the active destination aborts the packet from anywhere.
      if (state != DECODE_ADDRESS && flag_at(bus.soft_reset, dest_q)) begin
         state_nxt = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS: begin
               if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
                  dest_nxt  = bus.data_in;
                  state_nxt = flag_at(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                                   : WAIT_TILL_EMPTY;
               end
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
               if (flag_at(bus.fifo_full, dest_q))
                  state_nxt = FIFO_FULL_STATE;
               else if (!bus.pkt_valid)
                  state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!flag_at(bus.fifo_full, dest_q))
                  state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)
                  state_nxt = DECODE_ADDRESS;
               else if (bus.low_pkt_valid)
                  state_nxt = LOAD_PARITY;
               else
                  state_nxt = LOAD_DATA;
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_nxt = flag_at(bus.fifo_full, dest_q) ? FIFO_FULL_STATE
                                                          : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (flag_at(bus.fifo_empty, dest_q))
                  state_nxt = LOAD_FIRST_DATA;
            end
            default: state_nxt = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      full_state    = 1'b0;
      rst_int_reg   = 1'b0;
      write_enb_reg = 1'b0;
      busy          = 1'b1;
      case (state)
         DECODE_ADDRESS: begin
            detect_add = 1'b1;
            busy       = 1'b0;
         end
         LOAD_FIRST_DATA: lfd_state = 1'b1;
         LOAD_DATA: begin
            ld_state      = 1'b1;
            write_enb_reg = 1'b1;
            busy          = 1'b0;
         end
         FIFO_FULL_STATE: full_state = 1'b1;
         LOAD_AFTER_FULL: begin
            laf_state     = 1'b1;
            write_enb_reg = 1'b1;
         end
         LOAD_PARITY:        write_enb_reg = 1'b1;
         CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
         default: ;
      endcase
   end

   assign bus.detect_add    = detect_add;
   assign bus.lfd_state     = lfd_state;
   assign bus.ld_state      = ld_state;
   assign bus.laf_state     = laf_state;
   assign bus.full_state    = full_state;
   assign bus.rst_int_reg   = rst_int_reg;
   assign bus.write_enb_reg = write_enb_reg;
   assign bus.busy          = busy;
   assign bus.write_enb     = write_enb_reg ? addr_onehot(dest_q) : 3'b000;
   assign bus.dest_addr     = dest_q;

endmodule

// File: doc/router_ctrl_fsm.md
ROUTER_CTRL_FSM -- requirements
Module: router_ctrl_fsm

Interface
REQ-001 SHALL have: clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-003 SHALL have: pkt_valid  in  1  source asserts while header/payload bytes are on data_in.
REQ-004 SHALL have: data_in  in  2  bits [1:0] of the input byte (header destination address).
REQ-005 SHALL have: fifo_full  in  3  per-destination FIFO full flags.
REQ-006 SHALL have: fifo_empty  in  3  per-destination FIFO empty flags.
REQ-007 SHALL have: soft_reset  in  3  per-destination timeout resets from the sync block.
REQ-008 SHALL have: parity_done  in  1  register block has loaded the parity byte.
REQ-009 SHALL have: low_pkt_valid  in  1  register block saw pkt_valid fall while full.
REQ-010 SHALL have: busy  out  1  back-pressure to the source; source holds data_in while high.
REQ-011 SHALL have: detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state strobes to the register block.
REQ-012 SHALL have: write_enb_reg  out  1  register block may write a byte to a FIFO.
REQ-013 SHALL have: write_enb  out  3  one-hot FIFO write enable = write_enb_reg gated by latched address.
REQ-014 SHALL have: rst_int_reg  out  1  register block clears its internal parity state.
REQ-015 SHALL have: dest_addr  out  2  latched destination of the packet in progress.

Function
REQ-016 SHALL implement a Moore FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-017 DECODE_ADDRESS: if pkt_valid and data_in!=2'b11, latch dest_addr=data_in; go to LOAD_FIRST_DATA if fifo_empty[data_in], else go to WAIT_TILL_EMPTY; otherwise stay.
REQ-018 DECODE_ADDRESS with pkt_valid and data_in==2'b11 SHALL stay (packet dropped) and leave dest_addr unchanged.
REQ-019 LOAD_FIRST_DATA SHALL go unconditionally to LOAD_DATA.
REQ-020 LOAD_DATA: fifo_full[dest_addr] -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay; full takes priority.
REQ-021 FIFO_FULL_STATE: stay while fifo_full[dest_addr]; else -> LOAD_AFTER_FULL.
REQ-022 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-023 LOAD_PARITY SHALL go unconditionally to CHECK_PARITY_ERROR.
REQ-024 CHECK_PARITY_ERROR: fifo_full[dest_addr] -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-025 WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA; else stay.
REQ-026 soft_reset[dest_addr] high in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding all other transitions; soft_reset of other destinations SHALL be ignored.
REQ-027 Outputs SHALL decode from the current state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-028 write_enb_reg SHALL be high in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL only.
REQ-029 busy SHALL be low in DECODE_ADDRESS and LOAD_DATA, high in all other states.
REQ-030 write_enb SHALL be 3'b000 when write_enb_reg is low, else one-hot of dest_addr (00->001, 01->010, 10->100).

Reset
REQ-031 reset high SHALL, at the next rising edge, set state=DECODE_ADDRESS and dest_addr=2'b00 regardless of current state (mid-packet included), giving detect_add=1, all other outputs 0.
REQ-032 reset SHALL take priority over soft_reset and all transitions.

Structure
REQ-033 State encoding localparams and ADDR_INVALID=2'b11 SHALL live in a shared router package used by the register and sync blocks.
REQ-034 The block SHALL be a single module; no sub-module is required (state register, next-state logic, output decode).

Verification
REQ-035 Header 8'h40 (len 16, addr 0), fifo_empty=3'b111, no full -> LOAD_FIRST_DATA, then 16 cycles LOAD_DATA with busy=0, write_enb=3'b001; pkt_valid drop -> LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
REQ-036 Header addr 2 with fifo_empty[2]=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 for 5 cycles, then LOAD_FIRST_DATA; write_enb=3'b100 in LOAD_DATA.
REQ-037 fifo_full[0]=1 during LOAD_DATA for 3 cycles -> FIFO_FULL_STATE (full_state=1, busy=1, write_enb=0) 3 cycles, then LOAD_AFTER_FULL; with parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
REQ-038 Header 8'h43 (addr 3) -> state stays DECODE_ADDRESS, dest_addr unchanged, busy=0.
REQ-039 soft_reset[1] pulse in LOAD_DATA for dest 1 -> DECODE_ADDRESS next cycle; soft_reset[0] pulse for dest 1 -> no effect.
REQ-040 reset asserted in FIFO_FULL_STATE -> DECODE_ADDRESS, dest_addr=0, busy=0 after one edge.
